// File: rtl/subneg_core.sv
// Single-instruction SUBNEG core: mem[B] = mem[B] - mem[A]; branch to C on borrow/negative.
// Sequential multi-cycle FSM over a single-port handshaked memory, with one memory-mapped output word.
module subneg_core #(
    parameter int unsigned DW        = 8,
    parameter int unsigned AW        = 8,
    parameter int unsigned OUT_ADDR  = 21,
    parameter int unsigned SIGNED_BR = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_A = 3'd1,
        S_FETCH_B = 3'd2,
        S_FETCH_C = 3'd3,
        S_READ_A  = 3'd4,
        S_READ_B  = 3'd5,
        S_WRITE   = 3'd6,
        S_HALT    = 3'd7
    } state_e;

    state_e        state_q;
    logic [AW-1:0] addr_a_q;
    logic [AW-1:0] addr_b_q;
    logic [AW-1:0] addr_c_q;
    logic [DW-1:0] val_a_q;
    logic          br_q;
    logic          out_wr_q;

    logic [DW-1:0] res;
    logic          br;
    logic          to_out;

    // Result and branch decision are formed from the operand B word as it arrives in READ_B.
    always_comb begin
        res    = mem_rdata - val_a_q;
        br     = (SIGNED_BR != 0) ? res[DW-1] : (val_a_q > mem_rdata);
        to_out = (addr_b_q == AW'(OUT_ADDR));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc        <= '0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            addr_c_q  <= '0;
            val_a_q   <= '0;
            br_q      <= 1'b0;
            out_wr_q  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    mem_we <= 1'b0;
                    if (run) begin
                        mem_addr <= pc;
                        mem_re   <= 1'b1;
                        state_q  <= S_FETCH_A;
                    end else begin
                        mem_re <= 1'b0;
                    end
                end
                // Each read state captures on mem_ready and issues the next address on the same edge.
                S_FETCH_A: if (mem_ready) begin
                    addr_a_q <= mem_rdata[AW-1:0];
                    mem_addr <= pc + AW'(1);
                    state_q  <= S_FETCH_B;
                end
                S_FETCH_B: if (mem_ready) begin
                    addr_b_q <= mem_rdata[AW-1:0];
                    mem_addr <= pc + AW'(2);
                    state_q  <= S_FETCH_C;
                end
                S_FETCH_C: if (mem_ready) begin
                    addr_c_q <= mem_rdata[AW-1:0];
                    mem_addr <= addr_a_q;
                    state_q  <= S_READ_A;
                end
                S_READ_A: if (mem_ready) begin
                    val_a_q  <= mem_rdata;
                    mem_addr <= addr_b_q;
                    state_q  <= S_READ_B;
                end
                S_READ_B: if (mem_ready) begin
                    mem_re   <= 1'b0;
                    br_q     <= br;
                    out_wr_q <= to_out;
                    if (to_out) begin
                        out_data  <= res;
                        out_valid <= 1'b1;
                    end else begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_b_q;
                        mem_wdata <= res;
                    end
                    state_q <= S_WRITE;
                end
                // Output-port writes bypass memory and retire on the next edge.
                S_WRITE: if (out_wr_q || mem_ready) begin
                    mem_we <= 1'b0;
                    if (br_q && (addr_c_q == pc)) begin
                        halted  <= 1'b1;
                        state_q <= S_HALT;
                    end else begin
                        pc      <= br_q ? addr_c_q : pc + AW'(3);
                        state_q <= S_IDLE;
                    end
                end
                S_HALT: begin
                    mem_re <= 1'b0;
                    mem_we <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subneg_core.sv
// Scoreboard bench for subneg_core: directed programs, expected writes/outputs queued and
// matched by a monitor; unsigned-branch instance plus a signed-branch instance.
module tb_subneg_core;

    logic       clk;
    logic       reset;
    logic       run0, run1;
    logic       ready0, ready1;
    logic [7:0] addr0, addr1, wdata0, wdata1, rdata0, rdata1;
    logic       re0, re1, we0, we1;
    logic [7:0] pc0, pc1, out0, out1;
    logic       ov0, ov1, halt0, halt1;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic       ld_en, ld_sel;
    logic [7:0] ld_addr, ld_data;

    int checks;
    int failures;

    typedef struct {
        int         id;
        bit         is_out;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;
    ev_t sb_q[$];

    subneg_core #(.DW(8), .AW(8), .OUT_ADDR(21), .SIGNED_BR(0)) u_dut (
        .clk(clk), .reset(reset), .run(run0),
        .mem_addr(addr0), .mem_re(re0), .mem_we(we0), .mem_wdata(wdata0),
        .mem_rdata(rdata0), .mem_ready(ready0),
        .pc(pc0), .out_data(out0), .out_valid(ov0), .halted(halt0)
    );

    subneg_core #(.DW(8), .AW(8), .OUT_ADDR(21), .SIGNED_BR(1)) u_dut_s (
        .clk(clk), .reset(reset), .run(run1),
        .mem_addr(addr1), .mem_re(re1), .mem_we(we1), .mem_wdata(wdata1),
        .mem_rdata(rdata1), .mem_ready(ready1),
        .pc(pc1), .out_data(out1), .out_valid(ov1), .halted(halt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rdata0 = mem0[addr0];
    assign rdata1 = mem1[addr1];

    always @(posedge clk) begin
        if (ld_en && !ld_sel)    mem0[ld_addr] <= ld_data;
        else if (we0 && ready0)  mem0[addr0]   <= wdata0;
    end

    always @(posedge clk) begin
        if (ld_en && ld_sel)     mem1[ld_addr] <= ld_data;
        else if (we1 && ready1)  mem1[addr1]   <= wdata1;
    end

    task automatic exp_push(input int id, input bit is_out, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.id = id; e.is_out = is_out; e.addr = a; e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic sb_observe(input int id, input bit is_out, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected dut=%0d out=%0b actual addr=%0d data=%02h, required none",
                     id, is_out, a, d);
        end else begin
            e = sb_q.pop_front();
            if (e.id != id || e.is_out != is_out || e.addr != a || e.data != d) begin
                failures++;
                $display("FAIL sb_event actual dut=%0d out=%0b addr=%0d data=%02h, required dut=%0d out=%0b addr=%0d data=%02h",
                         id, is_out, a, d, e.id, e.is_out, e.addr, e.data);
            end
        end
    endtask

    // Monitor: completed memory writes and output pulses, plus strobe exclusivity.
    always @(negedge clk) begin
        if (we0 && ready0) sb_observe(0, 1'b0, addr0, wdata0);
        if (ov0)           sb_observe(0, 1'b1, 8'd21, out0);
        if (we1 && ready1) sb_observe(1, 1'b0, addr1, wdata1);
        if (ov1)           sb_observe(1, 1'b1, 8'd21, out1);
        if ((re0 === 1'b1 && we0 === 1'b1) || (re1 === 1'b1 && we1 === 1'b1)) begin
            checks++;
            failures++;
            $display("FAIL re_we_exclusive actual re0=%0b we0=%0b re1=%0b we1=%0b, required not both",
                     re0, we0, re1, we1);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h required=%02h", name, act, exp);
        end
    endtask

    task automatic load(input bit sel, input logic [7:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_sel = sel; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One zero-wait instruction: pc must be unchanged after 6 edges and updated after the 7th.
    task automatic run_instr(input bit sel, input logic [7:0] pc_start, input logic [7:0] pc_exp,
                             input string name);
        if (sel) run1 = 1'b1; else run0 = 1'b1;
        @(posedge clk); #1;
        run0 = 1'b0; run1 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check({name, "_pc_before"}, sel ? pc1 : pc0, pc_start);
        @(posedge clk); #1;
        check({name, "_pc_after"}, sel ? pc1 : pc0, pc_exp);
        check({name, "_re_idle"}, {7'd0, sel ? re1 : re0}, 8'd0);
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; run0 = 1'b0; run1 = 1'b0;
        ready0 = 1'b1; ready1 = 1'b1;
        ld_en = 1'b0; ld_sel = 1'b0; ld_addr = 8'd0; ld_data = 8'd0;
        @(posedge clk); #1;
        reset = 1'b0;

        check("rst_pc", pc0, 8'd0);
        check("rst_addr", addr0, 8'd0);
        check("rst_strobes", {6'd0, re0, we0}, 8'd0);
        check("rst_out", out0, 8'd0);
        check("rst_flags", {6'd0, ov0, halt0}, 8'd0);

        // Basic subtract, no branch: mem[11] = 7 - 3
        load(0, 8'd0, 8'd10); load(0, 8'd1, 8'd11); load(0, 8'd2, 8'd50);
        load(0, 8'd10, 8'd3); load(0, 8'd11, 8'd7);
        exp_push(0, 1'b0, 8'd11, 8'd4);
        run_instr(0, 8'd0, 8'd3, "nobranch");
        check("nobranch_mem", mem0[11], 8'd4);

        // Unsigned borrow branch: 7 - 9 = 0xFE, jump to 50
        do_reset();
        load(0, 8'd10, 8'd9); load(0, 8'd11, 8'd7);
        exp_push(0, 1'b0, 8'd11, 8'hFE);
        run_instr(0, 8'd0, 8'd50, "ubranch");

        // Signed-branch instance: 0x01 - 0x81 = 0x80 -> branch
        load(1, 8'd0, 8'd10); load(1, 8'd1, 8'd11); load(1, 8'd2, 8'd50);
        load(1, 8'd10, 8'h81); load(1, 8'd11, 8'h01);
        exp_push(1, 1'b0, 8'd11, 8'h80);
        run_instr(1, 8'd0, 8'd50, "sbranch");
        // 0x90 - 0x01 = 0x8F: negative, no unsigned borrow -> signed core still branches
        load(1, 8'd50, 8'd60); load(1, 8'd51, 8'd61); load(1, 8'd52, 8'd100);
        load(1, 8'd60, 8'h01); load(1, 8'd61, 8'h90);
        exp_push(1, 1'b0, 8'd61, 8'h8F);
        run_instr(1, 8'd50, 8'd100, "sneg");

        // Output port: 8 - 5 = 3 to address 21, no memory write
        do_reset();
        load(0, 8'd1, 8'd21); load(0, 8'd10, 8'd5); load(0, 8'd21, 8'd8);
        exp_push(0, 1'b1, 8'd21, 8'd3);
        run_instr(0, 8'd0, 8'd3, "outport");
        check("outport_data", out0, 8'd3);
        check("outport_mem21", mem0[21], 8'd8);

        // Wait states on FETCH_B: address 1 held for 4 cycles, 10 cycles total
        do_reset();
        load(0, 8'd1, 8'd11); load(0, 8'd10, 8'd3); load(0, 8'd11, 8'd7);
        exp_push(0, 1'b0, 8'd11, 8'd4);
        run0 = 1'b1;
        @(posedge clk); #1;
        run0 = 1'b0;
        @(posedge clk); #1;
        ready0 = 1'b0;
        check("wait_addr_0", addr0, 8'd1);
        check("wait_re_0", {7'd0, re0}, 8'd1);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("wait_addr_%0d", i), addr0, 8'd1);
            check($sformatf("wait_re_%0d", i), {7'd0, re0}, 8'd1);
        end
        ready0 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("wait_pc_cycle9", pc0, 8'd0);
        @(posedge clk); #1;
        check("wait_pc_cycle10", pc0, 8'd3);

        // Branch to 6, then self-branch at 6 halts
        do_reset();
        load(0, 8'd2, 8'd6); load(0, 8'd10, 8'd9); load(0, 8'd11, 8'd7);
        load(0, 8'd6, 8'd12); load(0, 8'd7, 8'd13); load(0, 8'd8, 8'd6);
        load(0, 8'd12, 8'd9); load(0, 8'd13, 8'd7);
        exp_push(0, 1'b0, 8'd11, 8'hFE);
        run_instr(0, 8'd0, 8'd6, "tohalt");
        check("tohalt_not_halted", {7'd0, halt0}, 8'd0);
        exp_push(0, 1'b0, 8'd13, 8'hFE);
        run_instr(0, 8'd6, 8'd6, "halt");
        check("halt_flag", {7'd0, halt0}, 8'd1);
        run0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check($sformatf("halt_strobes_%0d", i), {6'd0, re0, we0}, 8'd0);
            check($sformatf("halt_pc_%0d", i), pc0, 8'd6);
        end
        run0 = 1'b0;
        do_reset();
        check("halt_rst_pc", pc0, 8'd0);
        check("halt_rst_flag", {7'd0, halt0}, 8'd0);

        // Reset during a stalled WRITE drops the request
        load(0, 8'd2, 8'd50); load(0, 8'd10, 8'd3); load(0, 8'd11, 8'd7);
        run0 = 1'b1;
        @(posedge clk); #1;
        run0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        ready0 = 1'b0;
        check("wrst_we_pending", {7'd0, we0}, 8'd1);
        @(posedge clk); #1;
        check("wrst_we_held", {7'd0, we0}, 8'd1);
        do_reset();
        ready0 = 1'b1;
        check("wrst_we", {7'd0, we0}, 8'd0);
        check("wrst_pc", pc0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("wrst_re_%0d", i), {7'd0, re0}, 8'd0);
        end
        check("wrst_mem11", mem0[11], 8'd7);

        @(posedge clk); #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover actual=%0d pending required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/subneg_core.md
SUBNEG_CORE -- requirements
Module: subneg_core

Interface
REQ-001 Parameter DW, default 8: data word width in bits (DW >= AW).
REQ-002 Parameter AW, default 8: memory address width in bits.
REQ-003 Parameter OUT_ADDR, default 21: memory-mapped output address; writes to it go to out_data, not memory.
REQ-004 Parameter SIGNED_BR, default 0: 0 = branch on unsigned borrow (valA > valB); 1 = branch on signed negative result.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 run  input  1  enables the start of the next instruction.
REQ-008 mem_addr  output  AW  memory address, registered.
REQ-009 mem_re  output  1  read request, registered.
REQ-010 mem_we  output  1  write request, registered.
REQ-011 mem_wdata  output  DW  write data, registered.
REQ-012 mem_rdata  input  DW  read data, valid on an edge where mem_ready=1 and mem_re=1.
REQ-013 mem_ready  input  1  access complete; sampled every edge while mem_re or mem_we is high.
REQ-014 pc  output  AW  current program counter.
REQ-015 out_data  output  DW  last value written to OUT_ADDR.
REQ-016 out_valid  output  1  one-cycle pulse when out_data updates.
REQ-017 halted  output  1  core stopped on a self-branch.

Function
REQ-018 States: IDLE, FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE, HALT; one state active at a time.
REQ-019 IDLE: if run=1, load mem_addr=pc, mem_re=1 and enter FETCH_A; otherwise hold with mem_re=mem_we=0.
REQ-020 Each read state holds mem_addr and mem_re until an edge samples mem_ready=1; on that edge it captures mem_rdata and drives the next access's address on the same edge (no idle cycle between accesses).
REQ-021 FETCH_A captures addrA = mem_rdata[AW-1:0] and issues a read of pc+1. FETCH_B captures addrB and issues a read of pc+2. FETCH_C captures addrC and issues a read of addrA. All pc+k sums wrap mod 2^AW.
REQ-022 READ_A captures valA and issues a read of addrB. READ_B captures valB, computes res = valB - valA (mod 2^DW), and enters WRITE.
REQ-023 On entering WRITE with addrB != OUT_ADDR: mem_re=0, mem_we=1, mem_addr=addrB, mem_wdata=res; held until mem_ready=1 is sampled.
REQ-024 On entering WRITE with addrB == OUT_ADDR: no memory cycle; out_data=res and out_valid=1 for exactly one cycle; WRITE completes on the next edge regardless of mem_ready.
REQ-025 Branch condition br: SIGNED_BR=0 -> valA > valB unsigned; SIGNED_BR=1 -> res[DW-1]=1.
REQ-026 On WRITE completion: mem_we=0. If br and addrC == pc, enter HALT with halted=1 and pc unchanged. Otherwise pc = br ? addrC : pc+3 (mod 2^AW), and the core returns to IDLE.
REQ-027 HALT: all memory strobes stay 0 and pc is frozen; only reset exits.
REQ-028 mem_re and mem_we are never high in the same cycle.
REQ-029 Zero-wait memory (mem_ready tied 1) with run=1 takes 7 cycles per instruction: IDLE, five reads, one WRITE.
REQ-030 run is sampled only in IDLE; deasserting run mid-instruction has no effect until the instruction completes.

Reset
REQ-031 When reset=1 at an edge, on that edge: state=IDLE, pc=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, out_data=0, out_valid=0, halted=0; addrA/B/C and valA/B clear to 0.
REQ-032 Reset takes priority over every state, including mid-access and HALT; an outstanding request is dropped with no retry.

Verification
REQ-033 Zero-wait, mem[0..2]={10,11,50}, mem[10]=3, mem[11]=7, run=1 -> mem[11]=4 written; pc=3 at cycle 7; no branch.
REQ-034 Same program with mem[10]=9 -> write 0xFE to mem[11]; pc=50. With SIGNED_BR=1 and mem[10]=0x81, mem[11]=0x01 -> res=0x80, pc=50.
REQ-035 Operand B=21, valB=8, valA=5 -> out_data=3, out_valid high for exactly 1 cycle, no mem_we assertion.
REQ-036 mem_ready held low for 3 cycles on FETCH_B -> mem_addr=1 and mem_re held stable for 4 cycles; instruction completes in 10 cycles.
REQ-037 Instruction at pc=6 with C=6, valA > valB -> halted=1, pc stays 6, strobes stay 0 for 20 cycles. Reset then gives pc=0 and halted=0.
REQ-038 Reset asserted during WRITE with mem_ready=0 -> next cycle mem_we=0, pc=0, state IDLE; with run=0 no mem_re is asserted.
